// File: rtl/core_dispatcher.sv
`default_nettype none
// ============================================================================
//  Module   : core_dispatcher
//  Purpose  : Job scheduler in front of an array of matrix cores. Buffers job
//             descriptors in a FIFO, issues each job to a free core using a
//             round-robin grant, tracks per-core busy state from done pulses
//             and counts completed jobs.
//  Ports    : clk, rst_n             - clock, asynchronous active-low reset
//             job_valid/job_data     - job descriptor offer (valid/ready)
//             job_ready              - queue has room this cycle
//             core_start/core_job    - one-hot start pulse and its descriptor
//             core_done              - per-core completion pulses
//             busy                   - per-core ownership of a job
//             fifo_count             - jobs currently queued
//             jobs_done              - wrapping completed-job counter
//             idle                   - queue empty and no core busy
//  Revision : 1.0 - initial release
// ============================================================================
module core_dispatcher #(
    parameter int CORES      = 4,
    parameter int JOB_WIDTH  = 16,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          job_valid,
    input  logic [JOB_WIDTH-1:0]          job_data,
    output logic                          job_ready,
    output logic [CORES-1:0]              core_start,
    output logic [JOB_WIDTH-1:0]          core_job,
    input  logic [CORES-1:0]              core_done,
    output logic [CORES-1:0]              busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic [15:0]                   jobs_done,
    output logic                          idle
);

    localparam int c_PTR_W = $clog2(FIFO_DEPTH);
    localparam int c_CNT_W = c_PTR_W + 1;
    localparam int c_IDX_W = $clog2(CORES);
    localparam int c_PC_W  = $clog2(CORES + 1);

    localparam logic [c_CNT_W-1:0] c_FULL    = c_CNT_W'(FIFO_DEPTH);
    localparam logic [CORES-1:0]   c_ONE     = CORES'(1);
    localparam logic [c_IDX_W-1:0] c_LAST_RST = c_IDX_W'(CORES - 1);

    // Storage and state
    logic [JOB_WIDTH-1:0] r_mem [FIFO_DEPTH];
    logic [c_PTR_W-1:0]   r_wr_ptr;
    logic [c_PTR_W-1:0]   r_rd_ptr;
    logic [c_CNT_W-1:0]   r_count;
    logic [CORES-1:0]     r_busy;
    logic [CORES-1:0]     r_core_start;
    logic [JOB_WIDTH-1:0] r_core_job;
    logic [15:0]          r_jobs_done;
    logic [c_IDX_W-1:0]   r_last;

    // Combinational decode
    logic                 w_push;
    logic                 w_dispatch;
    logic                 w_grant_found;
    logic [c_IDX_W-1:0]   w_grant_idx;
    logic [c_IDX_W-1:0]   w_cand;
    logic [CORES-1:0]     w_grant_oh;
    logic [CORES-1:0]     w_done_eff;
    logic [c_PC_W-1:0]    w_done_cnt;

    assign job_ready  = (r_count != c_FULL);
    assign idle       = (r_count == '0) && (r_busy == '0);
    assign core_start = r_core_start;
    assign core_job   = r_core_job;
    assign busy       = r_busy;
    assign fifo_count = r_count;
    assign jobs_done  = r_jobs_done;

    assign w_push = job_valid && job_ready;

    // Round-robin search: first free core starting just after the last grant.
    // Only registered busy is used, so a core freed on this edge waits one
    // cycle before it can be granted again.
    always_comb begin
        w_grant_found = 1'b0;
        w_grant_idx   = '0;
        w_cand        = '0;
        for (int k = 1; k <= CORES; k++) begin
            w_cand = c_IDX_W'((int'(r_last) + k) % CORES);
            if (!w_grant_found && !r_busy[w_cand]) begin
                w_grant_found = 1'b1;
                w_grant_idx   = w_cand;
            end
        end
    end

    assign w_dispatch = (r_count != '0) && w_grant_found;
    assign w_grant_oh = w_dispatch ? (c_ONE << w_grant_idx) : '0;

    // Done pulses on cores that do not own a job are discarded.
    assign w_done_eff = core_done & r_busy;

    always_comb begin
        w_done_cnt = '0;
        for (int i = 0; i < CORES; i++) begin
            w_done_cnt = w_done_cnt + c_PC_W'(w_done_eff[i]);
        end
    end

    // Queue storage carries no reset: entries are only read after a push.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= job_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_count      <= '0;
            r_busy       <= '0;
            r_core_start <= '0;
            r_core_job   <= '0;
            r_jobs_done  <= '0;
            r_last       <= c_LAST_RST;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_PTR_W'(1);
            end
            if (w_dispatch) begin
                r_rd_ptr   <= r_rd_ptr + c_PTR_W'(1);
                r_core_job <= r_mem[r_rd_ptr];
                r_last     <= w_grant_idx;
            end
            case ({w_push, w_dispatch})
                2'b10:   r_count <= r_count + c_CNT_W'(1);
                2'b01:   r_count <= r_count - c_CNT_W'(1);
                default: r_count <= r_count;
            endcase
            // Grant targets a free core and done only affects busy cores,
            // so the two terms never collide on one bit.
            r_busy       <= (r_busy & ~w_done_eff) | w_grant_oh;
            r_core_start <= w_grant_oh;
            r_jobs_done  <= r_jobs_done + 16'(w_done_cnt);
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_core_dispatcher.sv
`default_nettype none
// ============================================================================
//  Module   : tb_core_dispatcher
//  Purpose  : Self-checking bench for core_dispatcher. Directed scenarios plus
//             randomized traffic compared every cycle against a queue-based
//             behavioural model of the scheduler.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_core_dispatcher;

    localparam int CORES = 4;
    localparam int JW    = 16;
    localparam int DEPTH = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          job_valid;
    logic [JW-1:0] job_data;
    logic          job_ready;
    logic [3:0]    core_start;
    logic [JW-1:0] core_job;
    logic [3:0]    core_done;
    logic [3:0]    busy;
    logic [2:0]    fifo_count;
    logic [15:0]   jobs_done;
    logic          idle;

    int n_checks = 0;
    int n_fail   = 0;

    // Behavioural model state
    logic [JW-1:0] m_q[$];
    logic [3:0]    m_busy;
    int            m_last;
    logic [15:0]   m_done;
    int            m_total;
    logic [3:0]    m_start;
    logic [JW-1:0] m_job;

    core_dispatcher #(.CORES(CORES), .JOB_WIDTH(JW), .FIFO_DEPTH(DEPTH)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .job_valid  (job_valid),
        .job_data   (job_data),
        .job_ready  (job_ready),
        .core_start (core_start),
        .core_job   (core_job),
        .core_done  (core_done),
        .busy       (busy),
        .fifo_count (fifo_count),
        .jobs_done  (jobs_done),
        .idle       (idle)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_q.delete();
        m_busy  = '0;
        m_last  = CORES - 1;
        m_done  = '0;
        m_start = '0;
        m_job   = '0;
    endtask

    // Apply one clock edge: advance the model from the current inputs, then
    // compare every output shortly after the edge.
    task automatic step(input string tag);
        bit push;
        int g;
        int c;
        push = job_valid && (m_q.size() < DEPTH);
        g = -1;
        if (m_q.size() > 0) begin
            for (int k = 1; k <= CORES; k++) begin
                c = (m_last + k) % CORES;
                if (g < 0 && !m_busy[c]) g = c;
            end
        end
        for (int i = 0; i < CORES; i++) begin
            if (core_done[i] && m_busy[i]) begin
                m_busy[i] = 1'b0;
                m_done    = m_done + 16'd1;
                m_total++;
            end
        end
        m_start = '0;
        if (g >= 0) begin
            m_start[g] = 1'b1;
            m_job      = m_q.pop_front();
            m_busy[g]  = 1'b1;
            m_last     = g;
        end
        if (push) m_q.push_back(job_data);

        @(posedge clk);
        #1;
        check({tag, ".core_start"}, 32'(core_start), 32'(m_start));
        check({tag, ".core_job"},   32'(core_job),   32'(m_job));
        check({tag, ".busy"},       32'(busy),       32'(m_busy));
        check({tag, ".fifo_count"}, 32'(fifo_count), 32'(m_q.size()));
        check({tag, ".jobs_done"},  32'(jobs_done),  32'(m_done));
        check({tag, ".job_ready"},  32'(job_ready),  32'(m_q.size() != DEPTH));
        check({tag, ".idle"},       32'(idle),       32'(m_q.size() == 0 && m_busy == 0));
    endtask

    task automatic check_reset(input string tag);
        check({tag, ".idle"},       32'(idle),       32'd1);
        check({tag, ".job_ready"},  32'(job_ready),  32'd1);
        check({tag, ".busy"},       32'(busy),       32'd0);
        check({tag, ".core_start"}, 32'(core_start), 32'd0);
        check({tag, ".core_job"},   32'(core_job),   32'd0);
        check({tag, ".jobs_done"},  32'(jobs_done),  32'd0);
        check({tag, ".fifo_count"}, 32'(fifo_count), 32'd0);
    endtask

    task automatic do_reset();
        rst_n     = 1'b0;
        job_valid = 1'b0;
        core_done = '0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        model_reset();
        check_reset("reset");
    endtask

    initial begin
        int cyc;
        m_total   = 0;
        rst_n     = 1'b0;
        job_valid = 1'b0;
        job_data  = '0;
        core_done = '0;
        model_reset();
        do_reset();

        // Single job: pushed at edge N, started after edge N+1
        job_valid = 1'b1; job_data = 16'h00A5;
        step("single_push");
        check("single_push.start_not_yet", 32'(core_start), 32'd0);
        job_valid = 1'b0;
        step("single_disp");
        check("single.core_start", 32'(core_start), 32'b0001);
        check("single.core_job",   32'(core_job),   32'h00A5);
        check("single.busy",       32'(busy),       32'b0001);
        check("single.fifo_count", 32'(fifo_count), 32'd0);

        // Round-robin ordering
        do_reset();
        job_valid = 1'b1;
        for (int j = 0; j < 4; j++) begin
            job_data = 16'(16'h1000 + j);
            step("rr_push");
            if (j > 0) check("rr.start_seq", 32'(core_start), 32'(1 << (j - 1)));
        end
        job_valid = 1'b0;
        step("rr_last");
        check("rr.start_core3", 32'(core_start), 32'b1000);
        check("rr.all_busy",    32'(busy),       32'b1111);
        core_done = 4'b0100;
        step("rr_done2");
        core_done = '0;
        job_valid = 1'b1; job_data = 16'h2005;
        step("rr_push5");
        job_valid = 1'b0;
        step("rr_disp5");
        check("rr.job5_core2", 32'(core_start), 32'b0100);
        check("rr.job5_data",  32'(core_job),   32'h2005);
        core_done = 4'b0011;
        step("rr_done01");
        core_done = '0;
        job_valid = 1'b1; job_data = 16'h2006;
        step("rr_push6");
        job_valid = 1'b0;
        step("rr_disp6");
        check("rr.job6_core0", 32'(core_start), 32'b0001);

        // Backpressure
        do_reset();
        job_valid = 1'b1;
        for (int j = 0; j < 8; j++) begin
            job_data = 16'(16'h3000 + j);
            step("bp_fill");
        end
        check("bp.fifo_full",  32'(fifo_count), 32'd4);
        check("bp.ready_low",  32'(job_ready),  32'd0);
        job_data = 16'h3008;
        step("bp_hold1");
        step("bp_hold2");
        check("bp.still_full", 32'(fifo_count), 32'd4);
        core_done = 4'b0010;
        step("bp_done1");
        core_done = '0;
        step("bp_disp");
        check("bp.disp_core1", 32'(core_start), 32'b0010);
        check("bp.disp_job",   32'(core_job),   32'h3004);
        check("bp.count3",     32'(fifo_count), 32'd3);
        check("bp.ready_high", 32'(job_ready),  32'd1);
        step("bp_accept");
        check("bp.accepted",   32'(fifo_count), 32'd4);
        job_valid = 1'b0;

        // Done accounting
        do_reset();
        job_valid = 1'b1;
        for (int j = 0; j < 4; j++) begin
            job_data = 16'(16'h4000 + j);
            step("acc_fill");
        end
        job_valid = 1'b0;
        step("acc_settle");
        core_done = 4'b1011;
        step("acc_done3");
        check("acc.jobs_done3", 32'(jobs_done), 32'd3);
        check("acc.busy0100",   32'(busy),      32'b0100);
        core_done = 4'b0001;
        step("acc_idle_done");
        check("acc.ignored",    32'(jobs_done), 32'd3);
        check("acc.busy_hold",  32'(busy),      32'b0100);
        core_done = '0;

        // Randomized traffic against the model
        for (int n = 0; n < 1500; n++) begin
            job_valid = 1'($urandom_range(0, 1));
            job_data  = 16'($urandom);
            core_done = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'b0000;
            step("rand");
        end

        // Asynchronous reset with 3 queued and 2 busy
        do_reset();
        job_valid = 1'b1;
        for (int j = 0; j < 7; j++) begin
            job_data = 16'(16'h5000 + j);
            step("mr_fill");
        end
        job_valid = 1'b0;
        core_done = 4'b0011;
        step("mr_done");
        core_done = '0;
        check("mr.queued3", 32'(fifo_count), 32'd3);
        check("mr.busy2",   32'(busy),       32'b1100);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset("midrst");
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        check_reset("midrst_rel");

        // Counter wrap: one completion per cycle until 65536 are exceeded
        m_total   = 0;
        job_valid = 1'b1;
        cyc       = 0;
        while (m_total < 65540 && cyc < 70000) begin
            job_data  = 16'($urandom);
            core_done = m_start;
            step("wrap");
            cyc++;
        end
        job_valid = 1'b0;
        core_done = '0;
        check("wrap.jobs_done", 32'(jobs_done), 32'(m_total - 65536));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
